// File: rtl/fft_peak_extractor_if.sv
// Sample stream in / spectrum summary out for fft_peak_extractor.
// The master drives FFT samples and the slave (the extractor) returns DC/AC results.
interface fft_peak_extractor_if #(
  parameter int DATA_W = 22,
  parameter int N_FFT  = 1024
);
  localparam int IDX_W = $clog2(N_FFT);

  logic                fft_dv;
  logic                fft_sync;
  logic [2*DATA_W-1:0] fft_data;
  logic [2*DATA_W-1:0] DC_comp;
  logic [2*DATA_W-1:0] AC_comp;
  logic [IDX_W-1:0]    ac_bin;
  logic                new_comp_DV;
  logic                frame_drop;

  modport master (output fft_dv, fft_sync, fft_data,
                  input  DC_comp, AC_comp, ac_bin, new_comp_DV, frame_drop);
  modport slave  (input  fft_dv, fft_sync, fft_data,
                  output DC_comp, AC_comp, ac_bin, new_comp_DV, frame_drop);
endinterface

// File: rtl/fft_peak_extractor.sv
// Post-FFT stage: |X|^2 per bin of a bit-reversed frame, DC capture and windowed AC peak search.
// Define SQRT_EN to report floor(sqrt()) amplitudes through a shared restoring square-root unit.
module fft_peak_extractor #(
  parameter int DATA_W = 22,
  parameter int N_FFT  = 1024,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 511
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fft_peak_extractor_if.slave  bus
);
  localparam int IDX_W = $clog2(N_FFT);
  localparam int MAG_W = 2*DATA_W;
  localparam int SW    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LO_IDX    = IDX_W'(BIN_LO);
  localparam logic [IDX_W-1:0] HI_IDX    = IDX_W'(BIN_HI);
  localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
  localparam logic [SW-1:0]    STEP_ONE  = SW'(1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(DATA_W-1);
`ifdef SQRT_EN
  localparam bit SQRT_ON = 1'b1;
`else
  localparam bit SQRT_ON = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, SQRT_DC, SQRT_AC, DONE} state_t;
  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [IDX_W-1:0] idx;
  } bin_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    step;
  logic [IDX_W-1:0] k, smp_idx;
  logic             accept, frame_start, load_out;
  logic             s1_vld;
  bin_t             s1;
  logic [MAG_W-1:0] dc_mag, pk_mag;
  logic [IDX_W-1:0] pk_bin;

  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
    for (int i = 0; i < IDX_W; i++) bitrev[i] = v[IDX_W-1-i];
  endfunction

  // Operands are widened before squaring so (-2^(DATA_W-1))^2 stays exact.
  logic signed [DATA_W-1:0] re, im;
  logic signed [MAG_W-1:0]  re_x, im_x, re_sq, im_sq;
  logic [MAG_W-1:0]         mag;
  assign re    = bus.fft_data[MAG_W-1:DATA_W];
  assign im    = bus.fft_data[DATA_W-1:0];
  assign re_x  = MAG_W'(re);
  assign im_x  = MAG_W'(im);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.fft_dv && bus.fft_sync) state_nxt = COLLECT;
      COLLECT: if (bus.fft_dv && !bus.fft_sync && (&k)) state_nxt = FLUSH;
      FLUSH:   if (step == STEP_ONE) state_nxt = SQRT_ON ? SQRT_DC : DONE;
      SQRT_DC: if (step == STEP_LAST) state_nxt = SQRT_AC;
      SQRT_AC: if (step == STEP_LAST) state_nxt = DONE;
      DONE:    state_nxt = (bus.fft_dv && bus.fft_sync) ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept          = 1'b0;
    frame_start     = 1'b0;
    bus.frame_drop  = 1'b0;
    bus.new_comp_DV = 1'b0;
    unique case (state)
      IDLE: begin
        accept      = bus.fft_dv && bus.fft_sync;
        frame_start = bus.fft_dv && bus.fft_sync;
      end
      COLLECT: begin
        // k is never 0 here, so a sync sample always aborts and restarts the frame
        accept         = bus.fft_dv;
        frame_start    = bus.fft_dv && bus.fft_sync;
        bus.frame_drop = bus.fft_dv && bus.fft_sync;
      end
      DONE: begin
        bus.new_comp_DV = 1'b1;
        accept          = bus.fft_dv && bus.fft_sync;
        frame_start     = bus.fft_dv && bus.fft_sync;
        bus.frame_drop  = bus.fft_dv && !bus.fft_sync;
      end
      default: bus.frame_drop = bus.fft_dv;
    endcase
  end

  assign load_out = (state_nxt == DONE);
  assign smp_idx  = frame_start ? '0 : k;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                step <= '0;
    else if (state_nxt != state) step <= '0;
    else                         step <= step + STEP_ONE;

  // ---------------- magnitude pipeline ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k      <= '0;
      s1_vld <= 1'b0;
      s1     <= '0;
      dc_mag <= '0;
      pk_mag <= '0;
      pk_bin <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        k      <= smp_idx + ONE_IDX;
        s1.mag <= mag;
        s1.idx <= bitrev(smp_idx);
      end
      // frame start wins over a stale stage-1 sample left by an aborted frame
      if (frame_start) begin
        pk_mag <= '0;
        pk_bin <= LO_IDX;
      end else if (s1_vld) begin
        if (s1.idx == '0) dc_mag <= s1.mag;
        if (s1.idx >= LO_IDX && s1.idx <= HI_IDX && s1.mag > pk_mag) begin
          pk_mag <= s1.mag;
          pk_bin <= s1.idx;
        end
      end
    end
  end

`ifdef SQRT_EN
  // ---------------- restoring square root, one root bit per cycle ----------------
  logic [MAG_W-1:0]  sq_rad;
  logic [DATA_W+1:0] sq_rem;
  logic [DATA_W-1:0] sq_root, root_nxt, dc_root;
  logic [DATA_W+3:0] rem_sh, trial;
  logic              ge;

  always_comb begin
    rem_sh   = {sq_rem, sq_rad[MAG_W-1 -: 2]};
    trial    = {2'b00, sq_root, 2'b01};
    ge       = (rem_sh >= trial);
    root_nxt = {sq_root[DATA_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq_rad  <= '0;
      sq_rem  <= '0;
      sq_root <= '0;
      dc_root <= '0;
    end else if (state == FLUSH || (state == SQRT_DC && step == STEP_LAST)) begin
      sq_rad  <= (state == FLUSH) ? dc_mag : pk_mag;
      sq_rem  <= '0;
      sq_root <= '0;
      if (state == SQRT_DC) dc_root <= root_nxt;
    end else if (state == SQRT_DC || state == SQRT_AC) begin
      sq_rad  <= {sq_rad[MAG_W-3:0], 2'b00};
      sq_rem  <= (DATA_W+2)'(ge ? rem_sh - trial : rem_sh);
      sq_root <= root_nxt;
    end
  end
`endif

  // ---------------- result registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.DC_comp <= '0;
      bus.AC_comp <= '0;
      bus.ac_bin  <= '0;
    end else if (load_out) begin
`ifdef SQRT_EN
      bus.DC_comp <= MAG_W'(dc_root);
      bus.AC_comp <= MAG_W'(root_nxt);
`else
      bus.DC_comp <= dc_mag;
      bus.AC_comp <= pk_mag;
`endif
      bus.ac_bin  <= pk_bin;
    end
  end
endmodule

// File: tb/tb_fft_peak_extractor.sv
// Directed + randomized bench for fft_peak_extractor (N_FFT=16, window 1..7), model-checked.
module tb_fft_peak_extractor;
  localparam int DATA_W = 22;
  localparam int N_FFT  = 16;
  localparam int IDX_W  = 4;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 7;
`ifdef SQRT_EN
  localparam int  LAT   = 3 + 2*DATA_W;
  localparam bit  SQ    = 1'b1;
`else
  localparam int  LAT   = 3;
  localparam bit  SQ    = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_peak_extractor_if #(.DATA_W(DATA_W), .N_FFT(N_FFT)) bus ();

  fft_peak_extractor #(.DATA_W(DATA_W), .N_FFT(N_FFT), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0, errors = 0;
  int cyc = 0, last_t = 0;
  int n_dv = 0, n_drop = 0, dv_cyc = 0, dbl = 0;
  logic [2*DATA_W-1:0] cap_dc, cap_ac;
  logic [IDX_W-1:0]    cap_bin;
  logic prev_dv = 1'b0, prev_drop = 1'b0;

  longint fr_re [N_FFT];
  longint fr_im [N_FFT];
  longint exp_dc, exp_ac;
  int     exp_bin;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor: counts events and latches results at the pulse
  always @(negedge clk) begin
    if (bus.new_comp_DV === 1'b1) begin
      n_dv++;
      dv_cyc  = cyc;
      cap_dc  = bus.DC_comp;
      cap_ac  = bus.AC_comp;
      cap_bin = bus.ac_bin;
    end
    if (bus.frame_drop === 1'b1) n_drop++;
    if ((bus.new_comp_DV === 1'b1 && prev_dv) || (bus.frame_drop === 1'b1 && prev_drop)) dbl++;
    prev_dv   = (bus.new_comp_DV === 1'b1);
    prev_drop = (bus.frame_drop === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < IDX_W; i++) if (v & (1 << i)) r |= 1 << (IDX_W-1-i);
    return r;
  endfunction

  function automatic longint isqrt(input longint m);
    longint lo = 0, hi = 64'd4194304, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= m) lo = mid; else hi = mid - 1;
    end
    return lo;
  endfunction

  // Reference: walk the frame in arrival order, strict '>' keeps the earliest tie.
  task automatic model();
    longint m, pk;
    int b;
    pk = 0; b = BIN_LO; exp_dc = 0;
    for (int kk = 0; kk < N_FFT; kk++) begin
      int n;
      n = brev(kk);
      m = fr_re[n]*fr_re[n] + fr_im[n]*fr_im[n];
      if (n == 0) exp_dc = m;
      if (n >= BIN_LO && n <= BIN_HI && m > pk) begin pk = m; b = n; end
    end
    exp_ac  = SQ ? isqrt(pk) : pk;
    exp_dc  = SQ ? isqrt(exp_dc) : exp_dc;
    exp_bin = b;
  endtask

  task automatic fill_const(input longint re, input longint im);
    for (int n = 0; n < N_FFT; n++) begin fr_re[n] = re; fr_im[n] = im; end
  endtask

  task automatic fill_random(input bit full);
    for (int n = 0; n < N_FFT; n++) begin
      if (full) begin
        fr_re[n] = longint'($urandom_range(0, 4194303)) - 2097152;
        fr_im[n] = longint'($urandom_range(0, 4194303)) - 2097152;
      end else begin
        fr_re[n] = longint'($urandom_range(0, 6)) - 3;
        fr_im[n] = longint'($urandom_range(0, 6)) - 3;
      end
    end
  endtask

  // Sends the first cnt samples in bit-reversed order; poke adds one stray sample right after.
  task automatic send_frame(input int cnt, input bit poke);
    for (int kk = 0; kk < cnt; kk++) begin
      logic [DATA_W-1:0] r, i;
      int n;
      n = brev(kk);
      r = fr_re[n][DATA_W-1:0];
      i = fr_im[n][DATA_W-1:0];
      @(posedge clk); #1;
      bus.fft_dv   = 1'b1;
      bus.fft_sync = (kk == 0);
      bus.fft_data = {r, i};
      last_t = cyc;
    end
    @(posedge clk); #1;
    bus.fft_sync = 1'b0;
    bus.fft_dv   = poke;
    if (poke) begin @(posedge clk); #1; bus.fft_dv = 1'b0; end
  endtask

  task automatic expect_result(input string tag, input int n0);
    for (int i = 0; i < 200 && n_dv == n0; i++) begin @(negedge clk); #1; end
    model();
    check({tag, "_dv_count"}, n_dv, n0 + 1);
    check({tag, "_latency"}, dv_cyc - last_t, LAT);
    check({tag, "_dc"}, cap_dc, exp_dc);
    check({tag, "_ac"}, cap_ac, exp_ac);
    check({tag, "_bin"}, cap_bin, exp_bin);
  endtask

  initial begin
    int n0, d0;
    bus.fft_dv = 1'b0; bus.fft_sync = 1'b0; bus.fft_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dc", bus.DC_comp, 0);
    check("rst_ac", bus.AC_comp, 0);
    check("rst_bin", bus.ac_bin, 0);
    check("rst_dv", bus.new_comp_DV, 0);
    check("rst_drop", bus.frame_drop, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // basic frame
    fill_const(1, 1);
    fr_re[0] = 100; fr_im[0] = 0; fr_re[3] = 30; fr_im[3] = 40;
    n0 = n_dv;
    send_frame(N_FFT, 1'b0);
    expect_result("basic", n0);
    check("basic_dc_abs", cap_dc, SQ ? 100 : 10000);
    check("basic_ac_abs", cap_ac, SQ ? 50 : 2500);
    check("basic_bin_abs", cap_bin, 3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hold_dc", bus.DC_comp, exp_dc);

    // tie inside window, larger bin outside window
    fill_const(0, 0);
    fr_re[0] = 7; fr_re[2] = 10; fr_re[5] = 10; fr_re[9] = 500;
    n0 = n_dv;
    send_frame(N_FFT, 1'b0);
    expect_result("tie", n0);
    check("tie_bin_abs", cap_bin, 2);
    check("tie_ac_abs", cap_ac, SQ ? 10 : 100);

    // full-scale negative corner
    fill_const(-2097152, -2097152);
    n0 = n_dv;
    send_frame(N_FFT, 1'b0);
    expect_result("ovf", n0);
    check("ovf_dc_abs", cap_dc, SQ ? 64'd2965820 : 64'd8796093022208);

    // non-sync sample in IDLE is ignored silently
    d0 = n_drop;
    @(posedge clk); #1 bus.fft_dv = 1'b1; bus.fft_sync = 1'b0;
    @(posedge clk); #1 bus.fft_dv = 1'b0;
    repeat (3) @(posedge clk);
    check("idle_nosync_drop", n_drop, d0);

    // stray sample during FLUSH
    fill_random(1'b1);
    n0 = n_dv; d0 = n_drop;
    send_frame(N_FFT, 1'b1);
    expect_result("flush", n0);
    check("flush_drop", n_drop, d0 + 1);

    // abort at k=9, then a complete frame
    n0 = n_dv; d0 = n_drop;
    fill_random(1'b1);
    send_frame(9, 1'b0);
    fill_random(1'b0);
    send_frame(N_FFT, 1'b0);
    expect_result("abort", n0);
    check("abort_drop", n_drop, d0 + 1);

    // random frames, wide and narrow (tie-heavy) ranges
    for (int f = 0; f < 4; f++) begin
      fill_random(f[0]);
      n0 = n_dv;
      send_frame(N_FFT, 1'b0);
      expect_result($sformatf("rand%0d", f), n0);
    end

    // reset during the post-frame computation (SQRT_AC when sqrt is built, else FLUSH)
    fill_random(1'b1);
    n0 = n_dv;
    send_frame(N_FFT, 1'b0);
    if (SQ) repeat (DATA_W + 5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_dc", bus.DC_comp, 0);
    check("midrst_ac", bus.AC_comp, 0);
    check("midrst_bin", bus.ac_bin, 0);
    check("midrst_dv", bus.new_comp_DV, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (60) @(posedge clk);
    check("midrst_no_dv", n_dv, n0);
    fill_const(1, 1);
    fr_re[0] = 100; fr_im[0] = 0; fr_re[3] = 30; fr_im[3] = 40;
    n0 = n_dv;
    send_frame(N_FFT, 1'b0);
    expect_result("postrst", n0);

    repeat (4) @(posedge clk);
    check("single_cycle_pulses", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_peak_extractor.md
# fft_peak_extractor

Parametrised post-FFT spectrum stage for the pulse-ox pipeline. It accepts one FFT output frame delivered in bit-reversed order and computes the squared magnitude of every bin. It captures the DC bin (natural index 0) and finds the strongest AC bin inside a configurable search window. It then presents DC and AC amplitudes plus the peak bin index to the downstream ratio/SpO2 logic with a one-cycle data-valid pulse.

## Interface
Parameters:
- DATA_W, 22, width of each signed FFT component (real, imag)
- N_FFT, 1024, frame length; power of two, 4..4096
- BIN_LO, 1, lowest natural bin included in AC peak search (≥1)
- BIN_HI, 511, highest natural bin included in AC peak search (BIN_LO ≤ BIN_HI < N_FFT)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- fft_dv  in  1  fft_data valid this cycle
- fft_sync  in  1  qualifies first sample of a frame (sampled only when fft_dv=1)
- fft_data  in  2*DATA_W  {real[2*DATA_W-1:DATA_W], imag[DATA_W-1:0]}, two's complement
- DC_comp  out  2*DATA_W  DC amplitude
- AC_comp  out  2*DATA_W  peak AC amplitude
- ac_bin  out  log2(N_FFT)  natural index of AC peak
- new_comp_DV  out  1  one-cycle pulse: DC_comp/AC_comp/ac_bin updated
- frame_drop  out  1  one-cycle pulse: samples discarded (see Operation)

## Operation
- FSM states: IDLE, COLLECT, FLUSH, SQRT_DC, SQRT_AC, DONE.
- IDLE: fft_dv=1 with fft_sync=1 enters COLLECT. That sample is bin-counter 0. Non-sync samples are ignored silently.
- COLLECT: each fft_dv=1 increments sample counter k (0..N_FFT-1). The natural bin index equals bit-reverse of k over log2(N_FFT) bits.
- Magnitude: mag = re*re + im*im, unsigned, 2*DATA_W bits, exact. The worst case (-2^(DATA_W-1) both) must not overflow.
- Pipeline stage 1 registers mag and the natural index. Stage 2 updates results:
  - index 0: store as DC.
  - BIN_LO ≤ index ≤ BIN_HI and mag > current peak: store as peak and record ac_bin. The comparison is strict, so on ties the first-arriving bin wins.
  - The peak register clears to 0 and ac_bin to BIN_LO at frame start.
- fft_sync=1 with fft_dv=1 while in COLLECT at k≠0 aborts the current frame. It pulses frame_drop and restarts the frame with this sample as k=0. Outputs are not updated.
- After sample k=N_FFT-1: FLUSH for two cycles to drain the pipeline. The next state is SQRT_DC if SQRT_EN is defined, otherwise DONE.
- Any fft_dv=1 outside IDLE/COLLECT is discarded and pulses frame_drop, once per discarded sample.
- DONE:
  - Register outputs.
  - Pulse new_comp_DV for 1 cycle.
  - Return to IDLE.
  - If fft_dv & fft_sync occur in that same cycle, go directly to COLLECT.
- Outputs hold their last values between updates.

## Timing
- Reset: all outputs 0, FSM IDLE, counters/accumulators 0. Asserting reset_n low mid-frame or mid-sqrt abandons all work immediately; no new_comp_DV follows.
- Throughput: one sample per cycle, back-to-back fft_dv permitted.
- Latency without SQRT_EN: last sample accepted at cycle t → new_comp_DV at t+3.
- Latency with SQRT_EN: new_comp_DV at t+3+2*DATA_W (DATA_W cycles per root).
- new_comp_DV and frame_drop are never asserted for more than one consecutive cycle per event. They may coincide only when a discarded sample lands in the DONE cycle.

## Configuration
- SQRT_EN defined:
  - Compiles a sequential restoring square-root unit, one result bit per cycle, DATA_W cycles, shared by DC then AC.
  - DC_comp = floor(sqrt(DC mag)) and AC_comp = floor(sqrt(peak mag)), both zero-extended to 2*DATA_W.
- SQRT_EN undefined:
  - No sqrt hardware; SQRT_DC/SQRT_AC are unreachable.
  - DC_comp and AC_comp carry the raw squared magnitudes.

## Test plan
- N_FFT=16, BIN_LO=1, BIN_HI=7, no SQRT_EN: frame in bit-reversed order. Natural bin 0 = (100,0), bin 3 = (30,40), all others (1,1). Required: DC_comp=10000, AC_comp=2500, ac_bin=3, new_comp_DV 3 cycles after last sample.
- Same frame with SQRT_EN, DATA_W=22: DC_comp=100, AC_comp=50, pulse at t+3+44.
- Tie and window test: bins 2 and 5 = (10,0), bin 9 = (500,0) outside window. Required: ac_bin=2, AC_comp=100.
- Overflow corner: every sample = (-2^21,-2^21). Required: DC_comp=2^43 (no SQRT_EN); with SQRT_EN, DC_comp=2965820 (floor(sqrt(2^43))).
- fft_sync reasserted at k=9, then a full frame follows. Required: one frame_drop pulse, one new_comp_DV reflecting only the second frame. A sample presented during FLUSH gives one frame_drop.
- reset_n pulsed low during SQRT_AC. Required: all outputs 0 immediately, no new_comp_DV, next full frame processed normally.
